serial_magcompare: RTL
======================

Name: serial_magcompare

Overview:
- Area-reduced, multi-cycle magnitude comparator. Produces the same flag set as the combinational tree comparator: EQ, signed LT, unsigned LTu.
- Scans operands MSB-first, DIGIT bits per cycle, and terminates early on the first differing digit.
- Sits between a producer that presents operand pairs and a consumer (branch/compare-set logic). Both sides use a valid/ready handshake.

Parameters:
- WIDTH, 64, operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle. Must be ≥1.
- NDIG (localparam), WIDTH/DIGIT, number of digits scanned.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- InValid  in  1  operand pair A/B is valid.
- InReady  out  1  block can accept operands.
- A  in  WIDTH  operand A; sampled only on accept.
- B  in  WIDTH  operand B; sampled only on accept.
- OutValid  out  1  EQ/LT/LTu are valid.
- OutReady  in  1  consumer accepts the result.
- EQ  out  1  A == B.
- LT  out  1  A < B, two's complement.
- LTu  out  1  A < B, unsigned.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - State is IDLE.
  - InReady=1, OutValid=0, EQ=0, LT=0, LTu=0.
  - Digit counter is 0; operand registers are don't-care.
- States:
  - IDLE: InReady=1, OutValid=0. InValid=1 at an edge captures A and B into registers Ar/Br, loads counter k=NDIG-1, and moves to SCAN.
  - SCAN: InReady=0, OutValid=0. Compare digit Ar[k*DIGIT +: DIGIT] against Br[k*DIGIT +: DIGIT], unsigned.
    - Digits differ: register LTu = (Adig < Bdig), EQ=0, LT = LTu ^ (Ar[WIDTH-1] ^ Br[WIDTH-1]); go to DONE.
    - Digits equal and k==0: register EQ=1, LT=0, LTu=0; go to DONE.
    - Otherwise: decrement k, stay in SCAN.
  - DONE: OutValid=1, InReady=0. EQ/LT/LTu held stable until OutReady=1 at an edge, then go to IDLE.
- Operand sampling: A/B changes after accept are ignored.
- Flags: exactly one of {EQ, LTu=1, LTu=0 with EQ=0} describes the unsigned relation. EQ=1 implies LT=LTu=0.
- Latency: accept edge to OutValid = j edges, where j is the 1-based position from MSB of the first differing digit. j=NDIG when operands are equal or differ only in the least significant digit.
- Throughput: no overlap. The earliest new accept is the edge after the output handshake, which itself returns the block to IDLE.
- Counter width is max(1, $clog2(NDIG)). k never wraps; SCAN exits at k==0.
- NDIG==1: the single SCAN cycle resolves; latency is 1.
- Reset mid-SCAN or mid-DONE: the in-flight result is discarded. The cycle after reset shows the reset values, and OutValid never pulses for the aborted op.
- reset takes priority over any simultaneous handshake.

Decomposition:
- Shared package cmp_pkg holds:
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} cmpstate_t.
  - Elaboration assertions checking WIDTH % DIGIT == 0 and DIGIT ≥ 1.
- One natural sub-module, magcompare_digit: parameterized DIGIT-bit unsigned comparator, outputs LT and GT. It is instantiated once on the muxed digit.
- Controller, counter and flag registers live in serial_magcompare.

Test Plan (WIDTH=64, DIGIT=4, NDIG=16):
1. A=B=0x0123456789ABCDEF -> OutValid 16 edges after accept; EQ=1, LT=0, LTu=0.
2. A=0x8000000000000000, B=0x0000000000000001 -> OutValid after 1 edge; EQ=0, LTu=0, LT=1.
3. A=0x0000000000000005, B=0x0000000000000007 -> OutValid after 16 edges; EQ=0, LTu=1, LT=1. Also A=0xFFFFFFFFFFFFFFFF, B=0 -> 1 edge, LTu=0, LT=1.
4. Result with OutReady held 0 for 5 cycles -> OutValid=1, InReady=0, flags constant. A/B and InValid toggling are ignored. OutReady=1 -> IDLE next cycle, InReady=1.
5. reset asserted on the 3rd SCAN cycle of case 1 -> next cycle IDLE with InReady=1, OutValid=0, flags 0. A following op with A=2, B=3 yields LTu=1, LT=1 after 16 edges.
6. Random back-to-back ops with random OutReady gaps -> each result matches $signed/$unsigned reference. Latency equals the first-differing-digit position.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state type and configuration check for the serial magnitude comparator
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} cmpstate_t;
  function automatic bit cfg_ok(int width, int digit);
    return digit >= 1 && width >= digit && (width % digit) == 0;
  endfunction
endpackage

// File: rtl/magcompare_digit.sv
// magcompare_digit: DIGIT-bit unsigned comparator
//   i_a, i_b : digits to compare
//   o_lt     : i_a < i_b
//   o_gt     : i_a > i_b
module magcompare_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt,
  output logic             o_gt
);
  assign o_lt = i_a < i_b;
  assign o_gt = i_a > i_b;
endmodule

// File: rtl/serial_magcompare.sv
// serial_magcompare: multi-cycle MSB-first digit-serial comparator producing EQ/LT/LTu
//   clk, reset          : clock, synchronous active-high reset
//   InValid/InReady/A/B : operand handshake, A/B captured on accept
//   OutValid/OutReady   : result handshake
//   EQ/LT/LTu           : A==B, signed A<B, unsigned A<B
module serial_magcompare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             EQ,
  output logic             LT,
  output logic             LTu
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_magcompare: WIDTH must be a nonzero multiple of DIGIT, DIGIT >= 1");
  end
  cmpstate_t        r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [KW-1:0]    r_k;
  logic             r_eq, r_lt, r_ltu;
  logic [DIGIT-1:0] w_adig, w_bdig;
  logic             w_dlt, w_dgt, w_diff, w_last;
  assign w_adig = r_a[r_k*DIGIT +: DIGIT];
  assign w_bdig = r_b[r_k*DIGIT +: DIGIT];
  magcompare_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a (w_adig),
    .i_b (w_bdig),
    .o_lt(w_dlt),
    .o_gt(w_dgt)
  );
  assign w_diff = w_dlt | w_dgt;
  assign w_last = r_k == '0;
  assign EQ  = r_eq;
  assign LT  = r_lt;
  assign LTu = r_ltu;
  always_comb begin
    w_next   = (r_state == IDLE) ? (InValid ? SCAN : IDLE)
             : (r_state == SCAN) ? ((w_diff || w_last) ? DONE : SCAN)
             : (OutReady ? IDLE : DONE);
    InReady  = r_state == IDLE;
    OutValid = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_ltu   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && InValid) begin
        r_a <= A;
        r_b <= B;
        r_k <= KW'(NDIG - 1);
      end
      if (r_state == SCAN) begin
        if (w_diff) begin
          // first differing digit settles the unsigned order; differing signs invert it for signed
          r_eq  <= 1'b0;
          r_ltu <= w_dlt;
          r_lt  <= w_dlt ^ r_a[WIDTH-1] ^ r_b[WIDTH-1];
        end else if (w_last) begin
          r_eq  <= 1'b1;
          r_lt  <= 1'b0;
          r_ltu <= 1'b0;
        end else begin
          r_k <= r_k - 1'b1;
        end
      end
    end
  end
endmodule
